// File: rtl/host_read_dma.sv
// Cache-line read engine: issues CCI-P c0 reads for a contiguous host buffer
// and forwards returned lines downstream tagged with their line index.
module host_read_dma #(
   parameter int ADDR_W          = 42,
   parameter int LEN_W           = 16,
   parameter int MAX_OUTSTANDING = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_lines,
   output logic              busy,
   output logic              done,
   output logic              req_valid,
   output logic [ADDR_W-1:0] req_addr,
   output logic [15:0]       req_mdata,
   input  logic              req_almfull,
   input  logic              rsp_valid,
   input  logic [15:0]       rsp_mdata,
   input  logic [511:0]      rsp_data,
   output logic              out_valid,
   output logic [LEN_W-1:0]  out_idx,
   output logic [511:0]      out_data
);

   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FIN
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] base_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issue_cnt_q;
   logic [LEN_W-1:0]  rsp_cnt_q;
   logic [OW-1:0]     outst_q;

   logic              active;
   logic              issue_ok;
   logic              rsp_ok;
   logic              rsp_dec;
   logic [LEN_W-1:0]  issue_cnt_d;
   logic [LEN_W-1:0]  rsp_cnt_d;
   logic [OW-1:0]     outst_d;

   always_comb begin
      active   = (state_q == ISSUE) || (state_q == DRAIN);
      issue_ok = (state_q == ISSUE) && !req_almfull &&
                 (outst_q < OW'(MAX_OUTSTANDING)) &&
                 (issue_cnt_q < len_q);
      rsp_ok   = active && rsp_valid;
      // a response with nothing outstanding is forwarded but never underflows
      rsp_dec  = rsp_ok && (outst_q != '0);
      issue_cnt_d = issue_cnt_q + LEN_W'(issue_ok);
      rsp_cnt_d   = rsp_cnt_q + LEN_W'(rsp_ok);
      outst_d     = outst_q;
      if (issue_ok && !rsp_dec) begin
         outst_d = outst_q + OW'(1);
      end else if (!issue_ok && rsp_dec) begin
         outst_d = outst_q - OW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         issue_cnt_q <= '0;
         rsp_cnt_q   <= '0;
         outst_q     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         req_valid   <= 1'b0;
         req_addr    <= '0;
         req_mdata   <= '0;
         out_valid   <= 1'b0;
         out_idx     <= '0;
         out_data    <= '0;
      end else begin
         done      <= 1'b0;
         req_valid <= 1'b0;
         out_valid <= rsp_ok;
         if (rsp_ok) begin
            out_idx  <= rsp_mdata[LEN_W-1:0];
            out_data <= rsp_data;
         end
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  base_q      <= base_addr;
                  len_q       <= num_lines;
                  issue_cnt_q <= '0;
                  rsp_cnt_q   <= '0;
                  outst_q     <= '0;
                  busy        <= 1'b1;
                  state_q     <= (num_lines != '0) ? ISSUE : FIN;
               end
            end
            ISSUE, DRAIN: begin
               if (issue_ok) begin
                  req_valid <= 1'b1;
                  req_addr  <= base_q + ADDR_W'(issue_cnt_q);
                  req_mdata <= 16'(issue_cnt_q);
               end
               issue_cnt_q <= issue_cnt_d;
               rsp_cnt_q   <= rsp_cnt_d;
               outst_q     <= outst_d;
               if (issue_cnt_d == len_q && rsp_cnt_d == len_q) begin
                  state_q <= FIN;
               end else if (issue_cnt_d == len_q) begin
                  state_q <= DRAIN;
               end
            end
            FIN: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_host_read_dma.sv
// Bench for host_read_dma: host model with delayed / reordered responses
// and a line-level reference of expected requests and forwarded lines.
module tb_host_read_dma;

   localparam int AW   = 42;
   localparam int LW   = 16;
   localparam int MAXA = 64;
   localparam int MAXB = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          sel;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] num_lines;
   logic          req_almfull;
   logic          rsp_valid;
   logic [15:0]   rsp_mdata;
   logic [511:0]  rsp_data;

   logic          a_busy, a_done, a_req_valid, a_out_valid;
   logic [AW-1:0] a_req_addr;
   logic [15:0]   a_req_mdata;
   logic [LW-1:0] a_out_idx;
   logic [511:0]  a_out_data;
   logic          b_busy, b_done, b_req_valid, b_out_valid;
   logic [AW-1:0] b_req_addr;
   logic [15:0]   b_req_mdata;
   logic [LW-1:0] b_out_idx;
   logic [511:0]  b_out_data;

   logic          busy, done, req_valid, out_valid;
   logic [AW-1:0] req_addr;
   logic [15:0]   req_mdata;
   logic [LW-1:0] out_idx;
   logic [511:0]  out_data;

   assign busy      = sel ? b_busy      : a_busy;
   assign done      = sel ? b_done      : a_done;
   assign req_valid = sel ? b_req_valid : a_req_valid;
   assign req_addr  = sel ? b_req_addr  : a_req_addr;
   assign req_mdata = sel ? b_req_mdata : a_req_mdata;
   assign out_valid = sel ? b_out_valid : a_out_valid;
   assign out_idx   = sel ? b_out_idx   : a_out_idx;
   assign out_data  = sel ? b_out_data  : a_out_data;

   host_read_dma #(.ADDR_W(AW), .LEN_W(LW), .MAX_OUTSTANDING(MAXA)) u_dut (
      .clk(clk), .rst(rst), .start(start & ~sel),
      .base_addr(base_addr), .num_lines(num_lines),
      .busy(a_busy), .done(a_done),
      .req_valid(a_req_valid), .req_addr(a_req_addr),
      .req_mdata(a_req_mdata), .req_almfull(req_almfull),
      .rsp_valid(rsp_valid & ~sel), .rsp_mdata(rsp_mdata),
      .rsp_data(rsp_data), .out_valid(a_out_valid),
      .out_idx(a_out_idx), .out_data(a_out_data)
   );

   host_read_dma #(.ADDR_W(AW), .LEN_W(LW), .MAX_OUTSTANDING(MAXB)) u_dut_b (
      .clk(clk), .rst(rst), .start(start & sel),
      .base_addr(base_addr), .num_lines(num_lines),
      .busy(b_busy), .done(b_done),
      .req_valid(b_req_valid), .req_addr(b_req_addr),
      .req_mdata(b_req_mdata), .req_almfull(req_almfull),
      .rsp_valid(rsp_valid & sel), .rsp_mdata(rsp_mdata),
      .rsp_data(rsp_data), .out_valid(b_out_valid),
      .out_idx(b_out_idx), .out_data(b_out_data)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit alm_prev;

   task automatic check(input string tag, input logic [511:0] got,
                        input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic rand_line(output logic [511:0] d);
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
   endtask

   // mode 0: in order after fixed lat; 1: random lat/order/almfull;
   // 2: hold all, return in order 3,0,2,1
   task automatic run_xfer(input bit use_b, input logic [AW-1:0] base,
                           input int n, input int mode, input int lat,
                           input int stall_at, input int stall_len,
                           output int t_first, output int t_last,
                           output int t_done, output int peak);
      int maxo = use_b ? MAXB : MAXA;
      int s, budget, pick, ord_pos, last_out, nreq, nout, inflight, ndone;
      int pend_idx[$];
      int pend_due[$];
      int elig[$];
      logic [15:0] exp_idx[$];
      logic [511:0] exp_dat[$];
      logic [15:0] ei;
      logic [511:0] ed;
      logic [AW-1:0] ea;
      int order[4] = '{3, 0, 2, 1};
      bit fin = 0;
      ord_pos = 0; last_out = -1; nreq = 0; nout = 0;
      inflight = 0; ndone = 0;
      t_first = -1; t_last = -1; t_done = -1; peak = 0;
      sel = use_b;
      base_addr = base;
      num_lines = LW'(n);
      rsp_valid = 1'b0;
      req_almfull = 1'b0;
      alm_prev = 1'b0;
      start = 1'b1;
      s = cyc;
      budget = 100 + 40 * n;
      while (!fin) begin
         tick();
         start = 1'b0;
         if (req_valid) begin
            check("req_alm", alm_prev, 0);
            check("req_cnt", nreq < n, 1);
            ea = base + AW'(nreq);
            check("req_addr", req_addr, ea);
            check("req_mdata", req_mdata, 16'(nreq));
            if (t_first < 0) t_first = cyc - s;
            t_last = cyc - s;
            pend_idx.push_back(nreq);
            pend_due.push_back(cyc + (lat > 0 ? lat : int'($urandom_range(1, 12))));
            nreq++;
            inflight++;
            if (inflight > peak) peak = inflight;
            check("outstanding", inflight <= maxo, 1);
         end
         if (out_valid) begin
            if (exp_idx.size() == 0) begin
               check("out_spurious", out_valid, 0);
            end else begin
               ei = exp_idx.pop_front();
               ed = exp_dat.pop_front();
               check("out_idx", out_idx, ei);
               check("out_data", out_data, ed);
            end
            nout++;
            last_out = cyc - s;
         end
         if (done) begin
            ndone++;
            t_done = cyc - s;
            check("done_nout", nout, n);
            check("done_nreq", nreq, n);
            check("done_busy", busy, 0);
            check("done_after_out", last_out <= t_done, 1);
         end
         rsp_valid = 1'b0;
         pick = -1;
         if (mode == 2) begin
            if (nreq == n && ord_pos < n) begin
               foreach (pend_idx[i]) if (pend_idx[i] == order[ord_pos]) pick = i;
               ord_pos++;
            end
         end else begin
            elig.delete();
            foreach (pend_due[i]) if (pend_due[i] <= cyc) elig.push_back(i);
            if (elig.size() > 0)
               pick = (mode == 1) ? elig[$urandom_range(0, elig.size() - 1)] : elig[0];
         end
         if (pick >= 0) begin
            rsp_valid = 1'b1;
            rsp_mdata = 16'(pend_idx[pick]);
            rand_line(rsp_data);
            exp_idx.push_back(rsp_mdata);
            exp_dat.push_back(rsp_data);
            pend_idx.delete(pick);
            pend_due.delete(pick);
            inflight--;
         end
         if (mode == 1) req_almfull = ($urandom_range(0, 3) == 0);
         else req_almfull = (cyc - s >= stall_at) && (cyc - s < stall_at + stall_len);
         alm_prev = req_almfull;
         if (t_done >= 0 && cyc - s >= t_done + 4) fin = 1;
         if (cyc - s > budget) begin
            check("timeout", 0, 1);
            fin = 1;
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
      end
      rsp_valid = 1'b0;
      req_almfull = 1'b0;
      check("done_cnt", ndone, 1);
      check("busy_end", busy, 0);
      check("lines_out", nout, n);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int tf, tl, td, pk, seen, k;
      logic [AW-1:0] wb;
      rst = 1'b1; start = 1'b0; sel = 1'b0;
      base_addr = '0; num_lines = '0;
      req_almfull = 1'b0; rsp_valid = 1'b0;
      rsp_mdata = '0; rsp_data = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_req_valid", req_valid, 0);
      check("rst_req_addr", req_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      rst = 1'b0;
      tick();

      run_xfer(0, 42'h1000, 4, 0, 5, 0, 0, tf, tl, td, pk);
      check("t1_first_req", tf, 2);
      check("t1_last_req", tl, 5);

      run_xfer(1, 42'h2340, 8, 0, 10, 0, 0, tf, tl, td, pk);
      check("t2_peak", pk, 2);

      run_xfer(0, 42'h2000, 12, 0, 3, 4, 6, tf, tl, td, pk);
      check("t3_first_req", tf, 2);
      check("t3_last_req", tl, 19);

      run_xfer(0, 42'h3000, 4, 2, 0, 0, 0, tf, tl, td, pk);

      wb = {AW{1'b1}};
      wb = wb - AW'(1);
      run_xfer(0, wb, 4, 0, 4, 0, 0, tf, tl, td, pk);

      run_xfer(0, 42'h4000, 0, 0, 5, 0, 0, tf, tl, td, pk);
      check("t6_done_time", td, 2);
      check("t6_no_req", tf, -1);

      sel = 1'b0;
      base_addr = 42'h5000;
      num_lines = 16'd8;
      start = 1'b1;
      seen = 0;
      k = 0;
      while (seen < 3 && k < 20) begin
         tick();
         start = 1'b0;
         if (req_valid) seen++;
         k++;
      end
      check("t7_reqs_before_rst", seen, 3);
      rst = 1'b1;
      #1;
      check("t7_busy", busy, 0);
      check("t7_done", done, 0);
      check("t7_req_valid", req_valid, 0);
      check("t7_req_addr", req_addr, 0);
      check("t7_req_mdata", req_mdata, 0);
      check("t7_out_valid", out_valid, 0);
      check("t7_out_idx", out_idx, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rsp_valid = 1'b1;
         rsp_mdata = 16'(i);
         rand_line(rsp_data);
         tick();
         check("t7_late_out", out_valid, 0);
         check("t7_late_done", done, 0);
         check("t7_late_req", req_valid, 0);
      end
      rsp_valid = 1'b0;
      tick();
      run_xfer(0, 42'h6000, 8, 0, 3, 0, 0, tf, tl, td, pk);
      check("t7_restart_first", tf, 2);

      for (int r = 0; r < 8; r++) begin
         wb = {10'($urandom()), 32'($urandom())};
         run_xfer(bit'($urandom_range(0, 1)), wb,
                  int'($urandom_range(1, 24)), 1, 0, 0, 0,
                  tf, tl, td, pk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/host_read_dma.md
Name: host_read_dma

Overview:
- Cache-line read engine fed by the MMIO/CSR stage.
- Takes a host buffer cache-line address and a line count, then issues CCI-P channel-0 read requests.
- Observes host almost-full backpressure and caps outstanding requests.
- Forwards returned 512-bit lines downstream, each tagged with its line index.

Parameters:
- ADDR_W, 42: cache-line address width (CCI-P c0 request address).
- LEN_W, 16: line-count and line-index width; must be ≤16 so the index fits in mdata.
- MAX_OUTSTANDING, 64: maximum in-flight read requests; power of two, 1..2^LEN_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse, begin transfer
- base_addr  in  ADDR_W  first cache-line address, sampled on start
- num_lines  in  LEN_W  lines to read, sampled on start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the last response has been forwarded
- req_valid  out  1  c0 read request valid
- req_addr  out  ADDR_W  request cache-line address
- req_mdata  out  16  request tag = line index, zero-extended
- req_almfull  in  1  host c0TxAlmFull
- rsp_valid  in  1  c0 read response valid
- rsp_mdata  in  16  response tag
- rsp_data  in  512  response line
- out_valid  out  1  line valid (no backpressure)
- out_idx  out  LEN_W  line index (rsp_mdata[LEN_W-1:0])
- out_data  out  512  line data

Behaviour:
- Reset values: busy=0, done=0, req_valid=0, req_addr=0, req_mdata=0, out_valid=0, out_idx=0, out_data=0. All counters and state return to IDLE.
- All outputs are registered.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - On start: latch base_addr/num_lines, clear issue_cnt, rsp_cnt and outstanding, set busy.
  - Go to ISSUE if num_lines≠0; otherwise go to FIN.
  - start while not in IDLE is ignored.
- ISSUE, each cycle:
  - Condition: req_almfull==0, outstanding<MAX_OUTSTANDING and issue_cnt<num_lines.
  - If the condition holds: register req_valid=1, req_addr=base+issue_cnt (mod 2^ADDR_W, wraps silently), req_mdata=issue_cnt, then issue_cnt++.
  - Otherwise req_valid=0.
  - When issue_cnt reaches num_lines, go to DRAIN.
  - req_valid is a single-cycle pulse per request and is never held.
- First request appears the cycle after ISSUE is entered, i.e. 2 cycles after start.
- outstanding:
  - +1 on request issue, −1 on accepted rsp_valid.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows.
- Responses in ISSUE/DRAIN:
  - Each rsp_valid produces out_valid=1 the next cycle, with out_idx/out_data copied from the response; rsp_cnt++.
  - Responses may arrive in any order and are forwarded in arrival order.
- DRAIN: when rsp_cnt==num_lines (counting the current response), go to FIN.
- FIN: pulse done=1 for one cycle, aligned with or after the last out_valid; clear busy the same cycle; go to IDLE.
- num_lines=0: done pulses 2 cycles after start, with no requests issued.
- rsp_valid in IDLE/FIN (stray or post-reset): ignored, no out_valid, counters unchanged.
- Reset mid-transfer: immediate abort with no done. In-flight responses arriving later are ignored per the rule above.

Test Plan:
- base_addr=0x1000, num_lines=4, almfull=0, host returns in order after 5 cycles -> requests at addrs 0x1000..0x1003 with mdata 0..3 on consecutive cycles from cycle start+2; 4 out_valid with idx 0..3; single done pulse; busy low afterward.
- num_lines=8, MAX_OUTSTANDING=2, responses delayed 10 cycles -> outstanding never exceeds 2; exactly 8 requests; done after the 8th out_valid.
- req_almfull held 1 for 6 cycles mid-stream -> no req_valid during the stall; addresses continue contiguously afterward; no line skipped or duplicated.
- Responses returned in order 3,0,2,1 -> out_idx sequence 3,0,2,1 with matching data; done after the 4th.
- base_addr=2^42−2, num_lines=4 -> req_addr sequence 0x3FFFFFFFFFE, 0x3FFFFFFFFFF, 0, 1.
- num_lines=0 -> done at start+2, no requests. Then rst asserted during an 8-line transfer after 3 requests -> all outputs zero immediately; late responses produce no out_valid; a new start works normally.
